// File: rtl/proc_pkg.sv
// Shared processor definitions: opcode encodings, fetch FSM states and PC width.
package proc_pkg;

  localparam int PC_W = 8;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_MOV   = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_JMP   = 3'b110;
  localparam logic [2:0] OP_STORE = 3'b111;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    FETCH_IMM = 2'd2,
    ISSUE     = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: request/address out of the fetch unit, ack/data back.
interface fetch_unit_if;
  import proc_pkg::*;

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [7:0]      imem_data;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_data);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_data);
endinterface

// File: rtl/pc_counter.sv
// Program counter: loads RESET_PC on synchronous reset, increments by one with 8-bit wrap.
// Latency: new value visible the cycle after i_inc. No backpressure.
module pc_counter
  import proc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_inc,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_inc) begin
      r_pc <= r_pc + PC_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Fetch/decode front end: reads instruction (plus immediate for LOAD) and issues decoded fields.
// Latency: 1 cycle after ack (2 acks + 1 for LOAD); stall holds ISSUE. Optional FETCH_TIMEOUT_EN.
module fetch_unit
  import proc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 8'h00
`ifdef FETCH_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 15
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_unit_if.master    imem,
  input  logic            stall,
  output logic [2:0]      opCode,
  output logic [1:0]      rd,
  output logic [1:0]      rs,
  output logic [7:0]      imm,
  output logic            instr_valid,
  output logic [PC_W-1:0] pc,
  output logic            fetch_err
);

  fetch_state_t r_state;
  fetch_state_t w_next;
  logic         w_req;
  logic         w_ack;
  logic         w_hold;
  logic [2:0]   r_opcode;
  logic [1:0]   r_rd;
  logic [1:0]   r_rs;
  logic [7:0]   r_imm;

  // Acks only count while a request is actually on the bus.
  assign w_ack = w_req && imem.imem_ack;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_tmo_cnt;
  logic          r_backoff;
  logic          w_tmo;

  assign w_tmo = w_req && !imem.imem_ack && (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
      r_backoff <= 1'b0;
    end else begin
      r_backoff <= w_tmo;
      if (!w_req || imem.imem_ack || w_tmo) begin
        r_tmo_cnt <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + CW'(1);
      end
    end
  end

  // Error pulse coincides with the one-cycle request gap before the retry.
  assign w_hold    = r_backoff;
  assign fetch_err = r_backoff;
`else
  assign w_hold    = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      w_next = FETCH;
      FETCH:     if (w_ack) w_next = (imem.imem_data[7:5] == OP_LOAD) ? FETCH_IMM : ISSUE;
      FETCH_IMM: if (w_ack) w_next = ISSUE;
      ISSUE:     if (!stall) w_next = FETCH;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    w_req       = 1'b0;
    instr_valid = 1'b0;
    unique case (r_state)
      FETCH, FETCH_IMM: w_req = !w_hold;
      ISSUE:            instr_valid = 1'b1;
      default:          ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_opcode <= '0;
      r_rd     <= '0;
      r_rs     <= '0;
      r_imm    <= '0;
    end else if (w_ack && (r_state == FETCH)) begin
      r_opcode <= imem.imem_data[7:5];
      r_rd     <= imem.imem_data[4:3];
      r_rs     <= imem.imem_data[2:1];
      r_imm    <= 8'h00;
    end else if (w_ack && (r_state == FETCH_IMM)) begin
      r_imm    <= imem.imem_data;
    end
  end

  pc_counter #(.RESET_PC(RESET_PC)) u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_ack),
    .o_pc  (pc)
  );

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = pc;
  assign opCode         = r_opcode;
  assign rd             = r_rd;
  assign rs             = r_rs;
  assign imm            = r_imm;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, ADD/LOAD fetch, stall hold, PC wrap, reset mid-fetch, timeout.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall;
  logic [2:0] opCode;
  logic [1:0] rd;
  logic [1:0] rs;
  logic [7:0] imm;
  logic       instr_valid;
  logic [7:0] pc;
  logic       fetch_err;
  int         n_chk  = 0;
  int         n_pass = 0;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (bus.master),
    .stall       (stall),
    .opCode      (opCode),
    .rd          (rd),
    .rs          (rs),
    .imm         (imm),
    .instr_valid (instr_valid),
    .pc          (pc),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; bus.imem_ack = 1'b0; bus.imem_data = 8'h00;
    step(); step();
    n_chk++; if (pc !== 8'h00) $display("FAIL rst_pc: got %h want 00", pc); else n_pass++;
    n_chk++; if (instr_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", instr_valid); else n_pass++;
    n_chk++; if (bus.imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", bus.imem_req); else n_pass++;
    n_chk++; if ({opCode, rd, rs, imm} !== 15'd0) $display("FAIL rst_fields: got %h want 0", {opCode, rd, rs, imm}); else n_pass++;
    n_chk++; if (fetch_err !== 1'b0) $display("FAIL rst_err: got %b want 0", fetch_err); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_chk++; if (bus.imem_req !== 1'b0) $display("FAIL idle_req: got %b want 0", bus.imem_req); else n_pass++;
    step();
    n_chk++; if (bus.imem_req !== 1'b1) $display("FAIL fetch_req: got %b want 1", bus.imem_req); else n_pass++;
    n_chk++; if (bus.imem_addr !== 8'h00) $display("FAIL fetch_addr: got %h want 00", bus.imem_addr); else n_pass++;
  endtask

  task automatic test_add();
    bus.imem_ack = 1'b1; bus.imem_data = 8'h4A;
    step();
    bus.imem_ack = 1'b0;
    n_chk++; if (opCode !== 3'b010) $display("FAIL add_op: got %b want 010", opCode); else n_pass++;
    n_chk++; if (rd !== 2'd1 || rs !== 2'd1) $display("FAIL add_rdrs: got %0d/%0d want 1/1", rd, rs); else n_pass++;
    n_chk++; if (imm !== 8'h00) $display("FAIL add_imm: got %h want 00", imm); else n_pass++;
    n_chk++; if (instr_valid !== 1'b1) $display("FAIL add_valid: got %b want 1", instr_valid); else n_pass++;
    n_chk++; if (pc !== 8'h01) $display("FAIL add_pc: got %h want 01", pc); else n_pass++;
    n_chk++; if (bus.imem_req !== 1'b0) $display("FAIL add_issue_req: got %b want 0", bus.imem_req); else n_pass++;
    step();
    n_chk++; if (instr_valid !== 1'b0) $display("FAIL add_valid_drop: got %b want 0", instr_valid); else n_pass++;
    n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h01) $display("FAIL add_next: got req %b addr %h want 1 01", bus.imem_req, bus.imem_addr); else n_pass++;
  endtask

  task automatic test_load();
    bus.imem_ack = 1'b1; bus.imem_data = 8'h08;
    step();
    n_chk++; if (instr_valid !== 1'b0) $display("FAIL load_valid_early: got %b want 0", instr_valid); else n_pass++;
    n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h02) $display("FAIL load_imm_req: got req %b addr %h want 1 02", bus.imem_req, bus.imem_addr); else n_pass++;
    bus.imem_data = 8'h5C;
    step();
    bus.imem_ack = 1'b0;
    n_chk++; if (instr_valid !== 1'b1) $display("FAIL load_valid: got %b want 1", instr_valid); else n_pass++;
    n_chk++; if (opCode !== 3'b000 || rd !== 2'd1 || rs !== 2'd0) $display("FAIL load_fields: got %b/%0d/%0d want 000/1/0", opCode, rd, rs); else n_pass++;
    n_chk++; if (imm !== 8'h5C) $display("FAIL load_imm: got %h want 5c", imm); else n_pass++;
    n_chk++; if (pc !== 8'h03) $display("FAIL load_pc: got %h want 03", pc); else n_pass++;
    step();
  endtask

  task automatic test_stall();
    stall = 1'b1; bus.imem_ack = 1'b1; bus.imem_data = 8'hE6;
    step();
    bus.imem_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_chk++; if (instr_valid !== 1'b1 || bus.imem_req !== 1'b0) $display("FAIL stall_hold%0d: got valid %b req %b want 1 0", c, instr_valid, bus.imem_req); else n_pass++;
      n_chk++; if ({opCode, rd, rs, imm, pc} !== {3'b111, 2'd0, 2'd3, 8'h00, 8'h04}) $display("FAIL stall_out%0d: got %h want %h", c, {opCode, rd, rs, imm, pc}, {3'b111, 2'd0, 2'd3, 8'h00, 8'h04}); else n_pass++;
      if (c == 0) begin
        bus.imem_ack = 1'b1; bus.imem_data = 8'hFF;
      end else begin
        bus.imem_ack = 1'b0;
      end
      if (c < 2) step();
    end
    stall = 1'b0;
    step();
    n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h04 || instr_valid !== 1'b0) $display("FAIL stall_release: got req %b addr %h valid %b want 1 04 0", bus.imem_req, bus.imem_addr, instr_valid); else n_pass++;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 251; i++) begin
      bus.imem_ack = 1'b1; bus.imem_data = 8'h4A;
      step();
      bus.imem_ack = 1'b0;
      step();
    end
    n_chk++; if (pc !== 8'hFF || bus.imem_addr !== 8'hFF) $display("FAIL wrap_pre: got pc %h addr %h want ff ff", pc, bus.imem_addr); else n_pass++;
    bus.imem_ack = 1'b1; bus.imem_data = 8'h4A;
    step();
    bus.imem_ack = 1'b0;
    n_chk++; if (pc !== 8'h00) $display("FAIL wrap_pc: got %h want 00", pc); else n_pass++;
    step();
    n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) $display("FAIL wrap_addr: got req %b addr %h want 1 00", bus.imem_req, bus.imem_addr); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bus.imem_ack = 1'b1; bus.imem_data = 8'h08;
    step();
    rst_n = 1'b0; bus.imem_data = 8'h5C;
    step();
    bus.imem_ack = 1'b0;
    n_chk++; if (pc !== 8'h00) $display("FAIL rmid_pc: got %h want 00", pc); else n_pass++;
    n_chk++; if (instr_valid !== 1'b0 || bus.imem_req !== 1'b0) $display("FAIL rmid_ctl: got valid %b req %b want 0 0", instr_valid, bus.imem_req); else n_pass++;
    n_chk++; if ({opCode, rd, imm} !== 13'd0) $display("FAIL rmid_fields: got %h want 0", {opCode, rd, imm}); else n_pass++;
    rst_n = 1'b1;
    step();
    n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) $display("FAIL rmid_restart: got req %b addr %h want 1 00", bus.imem_req, bus.imem_addr); else n_pass++;
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    bus.imem_ack = 1'b0;
    for (int i = 1; i < 15; i++) begin
      n_chk++; if (bus.imem_req !== 1'b1 || fetch_err !== 1'b0) $display("FAIL tmo_wait%0d: got req %b err %b want 1 0", i, bus.imem_req, fetch_err); else n_pass++;
      step();
    end
    step();
    n_chk++; if (fetch_err !== 1'b1 || bus.imem_req !== 1'b0) $display("FAIL tmo_pulse: got err %b req %b want 1 0", fetch_err, bus.imem_req); else n_pass++;
    n_chk++; if (pc !== 8'h00) $display("FAIL tmo_pc: got %h want 00", pc); else n_pass++;
    step();
    n_chk++; if (fetch_err !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) $display("FAIL tmo_retry: got err %b req %b addr %h want 0 1 00", fetch_err, bus.imem_req, bus.imem_addr); else n_pass++;
    bus.imem_ack = 1'b1; bus.imem_data = 8'h4A;
    step();
    bus.imem_ack = 1'b0;
    n_chk++; if (instr_valid !== 1'b1 || opCode !== 3'b010 || pc !== 8'h01) $display("FAIL tmo_done: got valid %b op %b pc %h want 1 010 01", instr_valid, opCode, pc); else n_pass++;
  endtask
`else
  task automatic test_no_timeout();
    bus.imem_ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      n_chk++; if (bus.imem_req !== 1'b1 || fetch_err !== 1'b0 || bus.imem_addr !== 8'h00) $display("FAIL wait%0d: got req %b err %b addr %h want 1 0 00", i, bus.imem_req, fetch_err, bus.imem_addr); else n_pass++;
    end
    bus.imem_ack = 1'b1; bus.imem_data = 8'h4A;
    step();
    bus.imem_ack = 1'b0;
    n_chk++; if (instr_valid !== 1'b1 || opCode !== 3'b010 || pc !== 8'h01) $display("FAIL wait_done: got valid %b op %b pc %h want 1 010 01", instr_valid, opCode, pc); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_load();
    test_stall();
    test_wrap();
    test_reset_mid();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 8'h00: PC value loaded on reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 15: ack wait limit, used only with FETCH_TIMEOUT_EN.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, synchronous and active-low.
REQ-005 imem_req  out  1  instruction-memory read request.
REQ-006 imem_addr  out  8  read address (current PC).
REQ-007 imem_ack  in  1  memory ack; imem_data valid the same cycle.
REQ-008 imem_data  in  8  instruction/immediate byte.
REQ-009 stall  in  1  downstream not ready; hold the issued instruction.
REQ-010 opCode  out  3  decoded opcode, driving the control unit.
REQ-011 rd  out  2  destination register field.
REQ-012 rs  out  2  source register field.
REQ-013 imm  out  8  immediate byte; valid for LOAD only, else 8'h00.
REQ-014 instr_valid  out  1  opCode/rd/rs/imm hold a complete instruction.
REQ-015 pc  out  8  current program counter.
REQ-016 fetch_err  out  1  one-cycle pulse on ack timeout.

Function
REQ-017 Instruction byte format SHALL be opCode=[7:5], rd=[4:3], rs=[2:1]; bit 0 ignored.
REQ-018 FSM states SHALL be IDLE, FETCH, FETCH_IMM, ISSUE.
REQ-019 IDLE SHALL last exactly one cycle after reset, then go to FETCH.
REQ-020 In FETCH/FETCH_IMM, imem_req=1 and imem_addr=pc until imem_ack.
REQ-021 On each imem_ack, pc SHALL increment by 1, with modulo-256 wrap (8'hFF -> 8'h00).
REQ-022 FETCH ack with opCode 3'b000 (LOAD) SHALL latch fields and go to FETCH_IMM; other opcodes latch fields, set imm=8'h00 and go to ISSUE.
REQ-023 FETCH_IMM ack SHALL latch imm and go to ISSUE.
REQ-024 In ISSUE, instr_valid=1. With stall=0, go to FETCH next cycle; with stall=1, stay in ISSUE with all outputs held.
REQ-025 Minimum latency: non-LOAD ack to instr_valid is 1 cycle; LOAD is 2 acks plus 1 cycle.
REQ-026 instr_valid SHALL be 0 in every state except ISSUE; imem_req SHALL be 0 in IDLE and ISSUE.
REQ-027 imem_ack outside FETCH/FETCH_IMM SHALL be ignored (no PC change).

Reset
REQ-028 When rst_n=0 at a clock edge: state=IDLE, pc=RESET_PC, opCode=0, rd=0, rs=0, imm=0, instr_valid=0, imem_req=0, fetch_err=0.
REQ-029 Reset mid-fetch or mid-ISSUE SHALL abandon the instruction; a coincident imem_ack is discarded.

Configuration
REQ-030 With FETCH_TIMEOUT_EN defined: a cycle counter runs while imem_req=1 and clears on ack. After TIMEOUT_CYCLES cycles without ack, the unit pulses fetch_err for 1 cycle, drops imem_req for 1 cycle, then retries the same pc in the same state.
REQ-031 Without FETCH_TIMEOUT_EN: no counter, the unit waits indefinitely, and fetch_err is tied to 0.

Structure
REQ-032 Shared package proc_pkg SHALL hold opcode constants OP_LOAD..OP_STORE (3'b000..3'b111), the fetch state enum, and the PC width of 8.
REQ-033 The PC register and increment SHALL be a sub-module pc_counter (load, inc, wrap); the rest is in fetch_unit.

Verification
REQ-034 Reset release, memory returns 8'h4A (ADD, rd=1, rs=1) with immediate ack -> opCode=3'b010, rd=1, rs=1, imm=0, instr_valid high 1 cycle, pc=8'h01.
REQ-035 LOAD 8'h08 then byte 8'h5C -> opCode=0, rd=1, imm=8'h5C, instr_valid after second ack, pc advanced by 2.
REQ-036 stall=1 for 3 cycles during ISSUE -> outputs stable, imem_req=0, next fetch starts the cycle after stall falls.
REQ-037 pc=8'hFF, fetch ack -> pc=8'h00, next imem_addr=8'h00.
REQ-038 rst_n low in FETCH_IMM coincident with ack -> pc=RESET_PC, instr_valid=0, IDLE next.
REQ-039 FETCH_TIMEOUT_EN defined, ack withheld 15 cycles -> fetch_err pulse, imem_req low 1 cycle, retry at same address; ack then completes normally.
